// File: rtl/booth_mult_seq_if.sv
// Operand/handshake/result bundle for the sequential Booth multiplier.
// master: the side issuing multiplies; slave: the multiplier itself.
interface booth_mult_seq_if #(
    parameter int QW = 32,
    parameter int MW = 9
);
    localparam int PW = QW + MW;

    logic          start;
    logic          abort;
    logic [QW-1:0] q_in;
    logic [MW-1:0] m_in;
    logic          q_signed;
    logic          m_signed;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    modport master (
        output start, abort, q_in, m_in, q_signed, m_signed,
        input  busy, done, product
    );

    modport slave (
        input  start, abort, q_in, m_in, q_signed, m_signed,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one multiply in flight at a time.
// Both operands are widened by one bit (sign or zero) so that every
// signed/unsigned mode combination reduces to a plain signed Booth multiply.
// The QW+1-bit multiplier takes QW+1 add/shift steps; A carries two extra
// bits so A +/- M cannot overflow even for the most-negative multiplicand.
module booth_mult_seq #(
    parameter int QW = 32,
    parameter int MW = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_mult_seq_if.slave  bus
);
    localparam int PW = QW + MW;
    localparam int AW = MW + 2;
    localparam int CW = $clog2(QW + 2);
    localparam logic [CW-1:0] CNT_INIT = CW'(QW + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] m_q, m_d;
    logic [QW:0]   q_q, q_d;
    logic          q1_q, q1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [PW-1:0] product_q, product_d;

    logic [AW-1:0] a_sum;
    logic [AW-1:0] a_shr;
    logic [QW:0]   q_shr;
    logic          last_step;

    // One Booth step: conditional add/subtract, then arithmetic right shift of {A,Q,Q_1}
    always_comb begin
        a_sum = a_q;
        unique case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
        a_shr = {a_sum[AW-1], a_sum[AW-1:1]};
        q_shr = {a_sum[0], q_q[QW:1]};
    end

    assign last_step = (cnt_q == CW'(1));

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d     = {bus.q_signed & bus.q_in[QW-1], bus.q_in};
                    m_d     = {{2{bus.m_signed & bus.m_in[MW-1]}}, bus.m_in};
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    // Abort wins over completion: no done, product untouched
                    state_d = IDLE;
                end else begin
                    a_d   = a_shr;
                    q_d   = q_shr;
                    q1_d  = q_q[0];
                    cnt_d = cnt_q - CW'(1);
                    if (last_step) begin
                        // Low PW bits of {A,Q} are exact for every sign mode
                        product_d = {a_shr[MW-2:0], q_shr};
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: default 32x9 instance plus an 8x8 instance.
module tb_booth_mult_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.QW(32), .MW(9)) bus ();
    booth_mult_seq_if #(.QW(8),  .MW(8)) bus8 ();

    booth_mult_seq #(.QW(32), .MW(9)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    booth_mult_seq #(.QW(8),  .MW(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt;

    typedef struct {
        logic [31:0] q;
        logic [8:0]  m;
        logic        qs;
        logic        ms;
        logic [40:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: mathematical product of the operands as interpreted by their sign modes
    function automatic logic [40:0] model32(input logic [31:0] q, input logic [8:0] m,
                                            input logic qs, input logic ms);
        longint qv, mv, p;
        qv = qs ? longint'($signed(q)) : longint'(q);
        mv = ms ? longint'($signed(m)) : longint'(m);
        p  = qv * mv;
        return p[40:0];
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] q, input logic [7:0] m,
                                           input logic qs, input logic ms);
        longint qv, mv, p;
        qv = qs ? longint'($signed(q)) : longint'(q);
        mv = ms ? longint'($signed(m)) : longint'(m);
        p  = qv * mv;
        return p[15:0];
    endfunction

    // Present operands with start for one edge, then scramble the operands
    task automatic launch(input logic [31:0] q, input logic [8:0] m, input logic qs, input logic ms);
        bus.start = 1'b1; bus.q_in = q; bus.m_in = m; bus.q_signed = qs; bus.m_signed = ms;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.q_in = $urandom; bus.m_in = 9'($urandom);
        bus.q_signed = 1'($urandom); bus.m_signed = 1'($urandom);
        busy_cnt = bus.busy ? 1 : 0;
    endtask

    // Count cycles until done, bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (bus.busy) busy_cnt++;
        end while (!bus.done && cyc < 60);
    endtask

    task automatic run32(input string name, input logic [31:0] q, input logic [8:0] m,
                         input logic qs, input logic ms, input logic [40:0] exp);
        int cyc;
        launch(q, m, qs, ms);
        wait_done(cyc);
        check({name, "_latency"}, 64'(cyc), 64'd33);
        check({name, "_product"}, 64'(bus.product), 64'(exp));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [40:0] prev;
        logic [31:0] rq;
        logic [8:0]  rm;
        logic        rqs, rms;

        vecs[0] = '{32'hFFFFFFFF, 9'h1FF, 1'b1, 1'b1, 41'h1};
        vecs[1] = '{32'hFFFFFFFF, 9'h1FF, 1'b0, 1'b0, 41'h1FEFFFFFE01};
        vecs[2] = '{32'h80000000, 9'h100, 1'b1, 1'b0, 41'h18000000000};
        vecs[3] = '{32'h00000000, 9'h0AB, 1'b0, 1'b0, 41'h0};
        vecs[4] = '{32'h7FFFFFFF, 9'h100, 1'b1, 1'b1, 41'h18000000100};
        vecs[5] = '{32'h00000005, 9'h1FF, 1'b0, 1'b1, 41'h1FFFFFFFFFB};

        bus.start = 0; bus.abort = 0; bus.q_in = '0; bus.m_in = '0; bus.q_signed = 0; bus.m_signed = 0;
        bus8.start = 0; bus8.abort = 0; bus8.q_in = '0; bus8.m_in = '0; bus8.q_signed = 0; bus8.m_signed = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", 64'(bus.product), 64'd0);
        check("reset_product8", 64'(bus8.product), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 6; i++)
            run32($sformatf("vec%0d", i), vecs[i].q, vecs[i].m, vecs[i].qs, vecs[i].ms, vecs[i].exp);

        // Back-to-back: second start issued in the done cycle
        launch(32'h12345678, 9'h0F3, 1'b1, 1'b1);
        wait_done(cyc);
        check("b2b_first_product", 64'(bus.product), 64'(model32(32'h12345678, 9'h0F3, 1'b1, 1'b1)));
        launch(32'd3, 9'd5, 1'b0, 1'b0);
        wait_done(cyc);
        check("b2b_gap", 64'(cyc + 1), 64'd34);
        check("b2b_product", 64'(bus.product), 64'd15);
        @(posedge clk); #1;

        // Abort on RUN cycle 10
        prev = bus.product;
        launch(32'hDEADBEEF, 9'h07B, 1'b0, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        cyc = 0;
        repeat (40) begin
            if (bus.done) cyc++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(cyc), 64'd0);
        check("abort_product_held", 64'(bus.product), 64'(prev));

        // Abort coinciding with the final step
        launch(32'h00000007, 9'h003, 1'b0, 1'b0);
        repeat (32) begin @(posedge clk); #1; end
        check("abort_last_busy_before", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_last_done", 64'(bus.done), 64'd0);
        check("abort_last_busy", 64'(bus.busy), 64'd0);
        check("abort_last_product", 64'(bus.product), 64'(prev));

        // start together with abort in IDLE: start wins
        bus.abort = 1'b1;
        launch(32'd100, 9'd7, 1'b0, 1'b0);
        bus.abort = 1'b0;
        check("start_abort_busy", 64'(bus.busy), 64'd1);
        wait_done(cyc);
        check("start_abort_latency", 64'(cyc), 64'd33);
        check("start_abort_product", 64'(bus.product), 64'd700);
        @(posedge clk); #1;

        // start during RUN is ignored and not queued
        launch(32'hFFFFFFF0, 9'h011, 1'b1, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.q_in = 32'h0000_0009; bus.m_in = 9'h002;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(cyc);
        check("ignored_start_latency", 64'(cyc + 5), 64'd33);
        check("ignored_start_product", 64'(bus.product), 64'(model32(32'hFFFFFFF0, 9'h011, 1'b1, 1'b0)));
        @(posedge clk); #1;
        check("ignored_start_not_queued", 64'(bus.busy), 64'd0);

        // Randomized against the reference model
        for (int i = 0; i < 16; i++) begin
            rq = $urandom; rm = 9'($urandom); rqs = 1'($urandom); rms = 1'($urandom);
            if (i == 0) rm = 9'h100;
            if (i == 1) rq = 32'h80000000;
            launch(rq, rm, rqs, rms);
            wait_done(cyc);
            check($sformatf("rand%0d_latency", i), 64'(cyc), 64'd33);
            check($sformatf("rand%0d_product", i), 64'(bus.product), 64'(model32(rq, rm, rqs, rms)));
        end

        // Asynchronous reset mid-RUN
        launch(32'h0000_1234, 9'h055, 1'b0, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 64'(bus.busy), 64'd0);
        check("async_reset_done", 64'(bus.done), 64'd0);
        check("async_reset_product", 64'(bus.product), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset_idle", 64'(bus.busy), 64'd0);

        // 8x8 instance: -128 x -128 and random vectors
        for (int i = 0; i < 9; i++) begin
            logic [7:0] q8, m8;
            logic qs8, ms8;
            logic [15:0] exp8;
            if (i == 0) begin
                q8 = 8'h80; m8 = 8'h80; qs8 = 1'b1; ms8 = 1'b1; exp8 = 16'h4000;
            end else begin
                q8 = 8'($urandom); m8 = 8'($urandom); qs8 = 1'($urandom); ms8 = 1'($urandom);
                exp8 = model8(q8, m8, qs8, ms8);
            end
            bus8.start = 1'b1; bus8.q_in = q8; bus8.m_in = m8; bus8.q_signed = qs8; bus8.m_signed = ms8;
            @(posedge clk); #1;
            bus8.start = 1'b0; bus8.q_in = 8'($urandom); bus8.m_in = 8'($urandom);
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (!bus8.done && cyc < 30);
            check($sformatf("w8_%0d_latency", i), 64'(cyc), 64'd9);
            check($sformatf("w8_%0d_product", i), 64'(bus8.product), 64'(exp8));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
